activation_cache: RTL and testbench
===================================

Name: activation_cache

Overview:
- Upstream feeder for the dilated causal conv1d stage.
- Holds a circular history of the previous layer's D-channel activation vectors.
- On each new vector it presents four time-tapped vectors, spaced DILATION steps apart, as packed_a0..packed_a3, ready for the 4-tap kernel.
- One instance sits in front of each conv1d layer. DILATION differs per layer: 1, 2, 4, ...

Parameters:
- W, 16: bit width of each element (signed fixed point, 4.12).
- D, 8: number of channels per packed vector.
- DILATION, 1: tap spacing in time steps; legal range 1..64.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-high.
- packed_in  input  D*W  new activation vector x[t]. Element 0 is in the MSBs.
- in_v  input  1  packed_in valid. Single-cycle pulse.
- in_ready  output  1  high when in_v will be accepted.
- packed_a0  output  D*W  x[t-3*DILATION] (oldest tap).
- packed_a1  output  D*W  x[t-2*DILATION].
- packed_a2  output  D*W  x[t-DILATION].
- packed_a3  output  D*W  x[t] (newest tap).
- out_v  output  1  taps valid. Held high until the next accepted in_v.
- primed  output  1  high once at least 3*DILATION+1 vectors have been written since reset.

Behaviour:
- Storage:
  - DEPTH = 3*DILATION+1 entries of D*W bits, held in registers.
  - Write pointer wp counts 0..DEPTH-1 and wraps from DEPTH-1 to 0. It is an explicit compare, not a power-of-two mask.
- Reset, in the cycle rst is sampled high:
  - All DEPTH entries cleared to 0; wp=0.
  - Fill counter = 0; state = IDLE.
  - in_ready=1, out_v=0, primed=0, packed_a0..a3 = 0.
  - Reset in any state overrides everything, including an in_v in the same cycle.
- FSM states: IDLE, WRITE, READ, HOLD.
- IDLE:
  - in_ready=1.
  - On in_v: latch packed_in, go to WRITE.
- WRITE:
  - in_ready=0.
  - Store the latched vector at mem[wp]; record tap base = wp.
  - wp <= (wp==DEPTH-1) ? 0 : wp+1.
  - Fill counter increments, saturating at DEPTH; primed <= (new count == DEPTH).
  - out_v <= 0. Go to READ.
- READ:
  - in_ready=0.
  - Tap address for k in 1..3: base - k*DILATION; if negative, add DEPTH.
  - Register packed_a3 = mem[base], packed_a2 = mem[addr1], packed_a1 = mem[addr2], packed_a0 = mem[addr3].
  - Go to HOLD.
- HOLD:
  - out_v=1 and in_ready=1.
  - packed_a* remain stable.
  - On in_v: latch packed_in, out_v <= 0, go to WRITE.
- Latency:
  - in_v accepted at cycle n → out_v high from cycle n+3.
  - Maximum throughput is one vector per 3 cycles.
- in_v while in_ready=0 (WRITE or READ) is ignored: no write, no pointer change.
- Before primed, taps that reach back past the first written vector return 0 (zero left-padding). This holds because of the reset clear.
- Wrap-around: once more than DEPTH writes have occurred, the oldest entry is overwritten. The a0 tap always addresses the entry written 3*DILATION writes earlier.
- No arithmetic is applied to the data; vectors pass bit-exact.
- Element ordering of packed_in is preserved on every packed_a* output.

Test Plan:
- Reset then idle:
  - Stimulus: hold rst 2 cycles, release, idle 5 cycles.
  - Required: out_v=0, primed=0, in_ready=1, all packed_a*=0.
- First vector, DILATION=1:
  - Stimulus: in_v with all elements = 16'h1000 at cycle n.
  - Required: in_ready=0 at n+1 and n+2; out_v=1 at n+3 with a3 = all 16'h1000 and a2=a1=a0=0; primed=0.
- Sequential fill, DILATION=2:
  - Stimulus: write vectors with every element equal to t, for t=1..7.
  - Required after t=7: a3=7, a2=5, a1=3, a0=1; primed rises on write 7.
  - Required after t=4: a3=4, a2=2, a1=0, a0=0.
- Wrap-around, DILATION=1 (DEPTH=4):
  - Stimulus: write t=1..10.
  - Required after t=10: a3=10, a2=9, a1=8, a0=7, confirming the pointer wrap and negative-address correction.
- Dropped input:
  - Stimulus: assert in_v one cycle after an accepted in_v (state WRITE).
  - Required: the second vector is not stored; wp advances once; taps match a single write.
- Mid-operation reset:
  - Stimulus: assert rst during READ after 5 writes, then write a vector = 16'h0ABC.
  - Required: out_v=0 and taps=0 during reset; afterwards a3=16'h0ABC, others 0, primed=0.

Source files
------------

// File: rtl/activation_cache_if.sv
// Handshake and tap bus between an activation producer and the activation_cache history buffer.
interface activation_cache_if #(
    parameter int unsigned W = 16,
    parameter int unsigned D = 8
) ();
    logic [D*W-1:0] packed_in;
    logic           in_v;
    logic           in_ready;
    logic [D*W-1:0] packed_a0;
    logic [D*W-1:0] packed_a1;
    logic [D*W-1:0] packed_a2;
    logic [D*W-1:0] packed_a3;
    logic           out_v;
    logic           primed;

    modport master (
        output packed_in, in_v,
        input  in_ready, packed_a0, packed_a1, packed_a2, packed_a3, out_v, primed
    );

    modport slave (
        input  packed_in, in_v,
        output in_ready, packed_a0, packed_a1, packed_a2, packed_a3, out_v, primed
    );
endinterface

// File: rtl/activation_cache.sv
// Circular history of activation vectors presenting four dilated time taps to a 4-tap conv1d kernel.
module activation_cache #(
    parameter int unsigned W        = 16,
    parameter int unsigned D        = 8,
    parameter int unsigned DILATION = 1
) (
    input  logic               clk,
    input  logic               rst,
    activation_cache_if.slave  bus
);
    localparam int unsigned DW    = D * W;
    localparam int unsigned DEPTH = 3 * DILATION + 1;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned TW    = AW + 1;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, WRITE, READ, HOLD} state_e;

    state_e          state_q;
    logic [DW-1:0]   mem_q [DEPTH];
    logic [DW-1:0]   lat_q;
    logic [AW-1:0]   wp_q, wp_d;
    logic [AW-1:0]   base_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            in_ready_q, out_v_q, primed_q;
    logic [DW-1:0]   a0_q, a1_q, a2_q, a3_q;
    logic [AW-1:0]   addr1_c, addr2_c, addr3_c;

    // Address of the entry k*DILATION writes before base, folded back into 0..DEPTH-1.
    function automatic logic [AW-1:0] tap_addr(input logic [AW-1:0] base, input int unsigned k);
        logic [TW-1:0] b;
        logic [TW-1:0] off;
        b   = TW'(base);
        off = TW'(k * DILATION);
        if (b >= off) tap_addr = AW'(b - off);
        else          tap_addr = AW'(b + TW'(DEPTH) - off);
    endfunction

    always_comb begin
        wp_d    = (wp_q == AW'(DEPTH - 1)) ? '0 : wp_q + AW'(1);
        cnt_d   = (cnt_q == CW'(DEPTH)) ? cnt_q : cnt_q + CW'(1);
        addr1_c = tap_addr(base_q, 1);
        addr2_c = tap_addr(base_q, 2);
        addr3_c = tap_addr(base_q, 3);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
            state_q    <= IDLE;
            lat_q      <= '0;
            wp_q       <= '0;
            base_q     <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b1;
            out_v_q    <= 1'b0;
            primed_q   <= 1'b0;
            a0_q       <= '0;
            a1_q       <= '0;
            a2_q       <= '0;
            a3_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_v) begin
                        lat_q      <= bus.packed_in;
                        in_ready_q <= 1'b0;
                        state_q    <= WRITE;
                    end
                end
                WRITE: begin
                    mem_q[wp_q] <= lat_q;
                    base_q      <= wp_q;
                    wp_q        <= wp_d;
                    cnt_q       <= cnt_d;
                    primed_q    <= (cnt_d == CW'(DEPTH));
                    out_v_q     <= 1'b0;
                    state_q     <= READ;
                end
                READ: begin
                    a3_q       <= mem_q[base_q];
                    a2_q       <= mem_q[addr1_c];
                    a1_q       <= mem_q[addr2_c];
                    a0_q       <= mem_q[addr3_c];
                    in_ready_q <= 1'b1;
                    out_v_q    <= 1'b1;
                    state_q    <= HOLD;
                end
                HOLD: begin
                    if (bus.in_v) begin
                        lat_q      <= bus.packed_in;
                        out_v_q    <= 1'b0;
                        in_ready_q <= 1'b0;
                        state_q    <= WRITE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_v     = out_v_q;
    assign bus.primed    = primed_q;
    assign bus.packed_a0 = a0_q;
    assign bus.packed_a1 = a1_q;
    assign bus.packed_a2 = a2_q;
    assign bus.packed_a3 = a3_q;
endmodule

// File: tb/tb_activation_cache.sv
// Scoreboard bench for activation_cache with DILATION=1 and DILATION=2 instances.
module tb_activation_cache;
    localparam int unsigned W  = 16;
    localparam int unsigned D  = 8;
    localparam int unsigned DW = D * W;

    typedef struct {
        logic [DW-1:0] a0, a1, a2, a3;
        logic          primed;
    } exp_t;

    logic clk;
    logic rst;
    int   n_total;
    int   n_bad;

    exp_t          sb_q [$];
    logic [DW-1:0] hist0 [$];
    logic [DW-1:0] hist1 [$];

    activation_cache_if #(.W(W), .D(D)) bus0 ();
    activation_cache_if #(.W(W), .D(D)) bus1 ();

    activation_cache #(.W(W), .D(D), .DILATION(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    activation_cache #(.W(W), .D(D), .DILATION(2)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input int sel, input logic [DW-1:0] vec, input logic v);
        if (sel == 0) begin bus0.packed_in = vec; bus0.in_v = v; end
        else          begin bus1.packed_in = vec; bus1.in_v = v; end
    endtask

    function automatic logic rdy(input int sel);
        return (sel == 0) ? bus0.in_ready : bus1.in_ready;
    endfunction

    function automatic logic outv(input int sel);
        return (sel == 0) ? bus0.out_v : bus1.out_v;
    endfunction

    function automatic logic prm(input int sel);
        return (sel == 0) ? bus0.primed : bus1.primed;
    endfunction

    function automatic logic [DW-1:0] tap(input int sel, input int k);
        case (k)
            0:       return (sel == 0) ? bus0.packed_a0 : bus1.packed_a0;
            1:       return (sel == 0) ? bus0.packed_a1 : bus1.packed_a1;
            2:       return (sel == 0) ? bus0.packed_a2 : bus1.packed_a2;
            default: return (sel == 0) ? bus0.packed_a3 : bus1.packed_a3;
        endcase
    endfunction

    // Model entry written 'back' writes before the newest, zero if before the first write.
    function automatic logic [DW-1:0] hist_at(input int sel, input int back);
        int n;
        n = (sel == 0) ? hist0.size() : hist1.size();
        if (n - 1 - back < 0) return '0;
        return (sel == 0) ? hist0[n - 1 - back] : hist1[n - 1 - back];
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        hist0.delete();
        hist1.delete();
        sb_q.delete();
    endtask

    task automatic push_vec(input int sel, input logic [DW-1:0] vec, input bit drop);
        exp_t e;
        int   dil;
        int   cyc;
        int   n;
        dil = (sel == 0) ? 1 : 2;
        @(negedge clk);
        chk("rdy_before", DW'(rdy(sel)), DW'(1));
        drive(sel, vec, 1'b1);
        @(negedge clk);
        drive(sel, '0, 1'b0);
        if (sel == 0) hist0.push_back(vec); else hist1.push_back(vec);
        n        = (sel == 0) ? hist0.size() : hist1.size();
        e.a3     = hist_at(sel, 0);
        e.a2     = hist_at(sel, dil);
        e.a1     = hist_at(sel, 2 * dil);
        e.a0     = hist_at(sel, 3 * dil);
        e.primed = (n >= 3 * dil + 1);
        sb_q.push_back(e);
        cyc = 1;
        chk("rdy_write", DW'(rdy(sel)), DW'(0));
        chk("outv_write", DW'(outv(sel)), DW'(0));
        if (drop) begin
            drive(sel, ~vec, 1'b1);
            @(negedge clk);
            drive(sel, '0, 1'b0);
            cyc++;
        end
        while (!outv(sel) && cyc < 10) begin
            chk("rdy_busy", DW'(rdy(sel)), DW'(0));
            @(negedge clk);
            cyc++;
        end
        chk("latency", DW'(cyc), DW'(3));
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("a3", tap(sel, 3), e.a3);
            chk("a2", tap(sel, 2), e.a2);
            chk("a1", tap(sel, 1), e.a1);
            chk("a0", tap(sel, 0), e.a0);
            chk("primed", DW'(prm(sel)), DW'(e.primed));
            chk("rdy_hold", DW'(rdy(sel)), DW'(1));
        end
    endtask

    task automatic chk_idle(input int sel);
        chk("rst_outv", DW'(outv(sel)), DW'(0));
        chk("rst_primed", DW'(prm(sel)), DW'(0));
        chk("rst_rdy", DW'(rdy(sel)), DW'(1));
        for (int k = 0; k < 4; k++) chk("rst_tap", tap(sel, k), '0);
    endtask

    initial begin
        logic [DW-1:0] v;
        n_total = 0;
        n_bad   = 0;
        rst     = 1'b1;
        drive(0, '0, 1'b0);
        drive(1, '0, 1'b0);

        // Reset then idle
        do_reset();
        repeat (5) @(negedge clk);
        chk_idle(0);
        chk_idle(1);

        // First vector, DILATION=1
        push_vec(0, {8{16'h1000}}, 1'b0);

        // Wrap-around, DILATION=1
        do_reset();
        for (int t = 1; t <= 10; t++) push_vec(0, {8{16'(t)}}, 1'b0);
        chk("wrap_a0", tap(0, 0), {8{16'd7}});

        // Sequential fill, DILATION=2
        do_reset();
        for (int t = 1; t <= 7; t++) push_vec(1, {8{16'(t)}}, 1'b0);
        chk("fill_a0", tap(1, 0), {8{16'd1}});

        // Dropped input during WRITE, then distinct per-element vectors
        do_reset();
        v = {16'h0001, 16'h0102, 16'h0203, 16'h0304, 16'h0405, 16'h0506, 16'h0607, 16'h0708};
        push_vec(0, v, 1'b1);
        for (int i = 0; i < 4; i++) begin
            v = {$urandom, $urandom, $urandom, $urandom};
            push_vec(0, v, (i == 1));
        end
        for (int i = 0; i < 4; i++) begin
            v = {$urandom, $urandom, $urandom, $urandom};
            push_vec(1, v, (i == 2));
        end

        // Mid-operation reset during READ
        do_reset();
        for (int i = 0; i < 5; i++) push_vec(0, {8{16'(i + 20)}}, 1'b0);
        @(negedge clk);
        drive(0, {8{16'h5555}}, 1'b1);
        @(negedge clk);
        drive(0, '0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_idle(0);
        @(negedge clk);
        rst = 1'b0;
        hist0.delete();
        sb_q.delete();
        push_vec(0, {8{16'h0ABC}}, 1'b0);
        chk("post_rst_a3", tap(0, 3), {8{16'h0ABC}});

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
